// File: rtl/prbs31_checker_pkg.sv
// PRBS31 shared definitions: checker states, taps and the 64-bit advance.
// s[n] = s[n-31] ^ s[n-28]; bit 0 of a word is the earliest in time.
package prbs31_checker_pkg;

  localparam int unsigned PRBS_ORD   = 31;
  localparam int unsigned PRBS_TAP_A = 31;
  localparam int unsigned PRBS_TAP_B = 28;
  localparam int unsigned PRBS_W     = 64;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } prbs_chk_st_t;

  typedef struct packed {
    logic [PRBS_W-1:0]   bits;
    logic [PRBS_ORD-1:0] state;
  } prbs_adv_t;

  // state[0] is the oldest bit s[n-31], state[30] the newest s[n-1]
  function automatic prbs_adv_t prbs31_adv64(
    input logic [PRBS_ORD-1:0] seed
  );
    prbs_adv_t           r;
    logic [PRBS_ORD-1:0] st;
    logic                b;
    st     = seed;
    r.bits = '0;
    for (int i = 0; i < PRBS_W; i++) begin
      b         = st[PRBS_ORD-PRBS_TAP_A]
                ^ st[PRBS_ORD-PRBS_TAP_B];
      r.bits[i] = b;
      st        = {b, st[PRBS_ORD-1:1]};
    end
    r.state = st;
    return r;
  endfunction

endpackage

// File: rtl/prbs31_checker_if.sv
// Received word stream into the PRBS31 checker.
// Master drives data/valid, the checker is the slave.
interface prbs31_checker_if #(
  parameter int unsigned P_DATA_W = 64
);

  logic [P_DATA_W-1:0] data;
  logic                valid;

  modport master (
    output data,
    output valid
  );

  modport slave (
    input data,
    input valid
  );

endinterface

// File: rtl/prbs31_checker_adv.sv
// Combinational 64-bit parallel PRBS31 advance.
// Shared between the PRBS31 generator and checker.
module prbs31_adv
  import prbs31_checker_pkg::*;
(
  input  logic [PRBS_ORD-1:0] seed_i,
  output logic [PRBS_W-1:0]   bits_o,
  output logic [PRBS_ORD-1:0] state_o
);

  prbs_adv_t adv;

  // unrolled 64-step advance of the seed
  always_comb begin
    adv = prbs31_adv64(seed_i);
  end

  assign bits_o  = adv.bits;
  assign state_o = adv.state;

endmodule

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 receive checker with lock and error counters.
// Define PRBS_BIT_ERR_CNT_EN to build the bit error popcount counter.
module prbs31_checker
  import prbs31_checker_pkg::*;
#(
  parameter int unsigned P_DATA_W     = 64,
  parameter int unsigned P_LOCK_CNT   = 64,
  parameter int unsigned P_WIN        = 1024,
  parameter int unsigned P_UNLOCK_ERR = 16,
  parameter int unsigned P_CNT_W      = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  prbs31_checker_if.slave    rx,
  input  logic               clear_cnt_i,
  output logic               locked_o,
  output logic               word_err_o,
  output logic [P_CNT_W-1:0] word_cnt_o,
  output logic [P_CNT_W-1:0] err_cnt_o,
  output logic [P_CNT_W-1:0] bit_err_cnt_o
);

  localparam int unsigned LK_W  = $clog2(P_LOCK_CNT + 1);
  localparam int unsigned WIN_W = $clog2(P_WIN + 1);
  localparam int unsigned WE_W  = $clog2(P_UNLOCK_ERR + 1);

  prbs_chk_st_t        st_q, st_d;
  logic [PRBS_ORD-1:0] seed_q, seed_d;
  logic [PRBS_ORD-1:0] lfsr_q, lfsr_d;
  logic [LK_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [WE_W-1:0]     win_err_q, win_err_d;
  logic                word_err_q, word_err_d;
  logic [P_CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [P_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [P_DATA_W-1:0] data_w;
  logic [PRBS_ORD-1:0] tail_w;
  logic [PRBS_ORD-1:0] adv_seed;
  logic [PRBS_W-1:0]   exp_w;
  logic [PRBS_ORD-1:0] adv_st;
  logic                mis;
  logic                inc_word;
  logic                inc_err;

  assign data_w = rx.data;
  assign tail_w = data_w[P_DATA_W-1 -: PRBS_ORD];

  // locked: free-running local LFSR; otherwise last word's tail
  assign adv_seed = (st_q == LOCKED) ? lfsr_q : seed_q;

  prbs31_adv u_adv (
    .seed_i  (adv_seed),
    .bits_o  (exp_w),
    .state_o (adv_st)
  );

  assign mis = data_w != exp_w;

  // lock FSM next state, window tracking and error pulse
  always_comb begin
    st_d       = st_q;
    seed_d     = seed_q;
    lfsr_d     = lfsr_q;
    lock_cnt_d = lock_cnt_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    word_err_d = 1'b0;
    inc_word   = 1'b0;
    inc_err    = 1'b0;
    if (rx.valid) begin
      seed_d = tail_w;
      unique case (st_q)
        UNLOCKED: begin
          st_d       = LOCKING;
          lock_cnt_d = '0;
        end
        LOCKING: begin
          if (!mis && (seed_q != '0)) begin
            if (lock_cnt_q == LK_W'(P_LOCK_CNT - 1)) begin
              st_d       = LOCKED;
              lfsr_d     = tail_w;
              lock_cnt_d = '0;
              win_cnt_d  = '0;
              win_err_d  = '0;
            end else begin
              lock_cnt_d = lock_cnt_q + LK_W'(1);
            end
          end else begin
            lock_cnt_d = '0;
          end
        end
        LOCKED: begin
          lfsr_d     = adv_st;
          inc_word   = 1'b1;
          inc_err    = mis;
          word_err_d = mis;
          if (mis && (win_err_q ==
              WE_W'(P_UNLOCK_ERR - 1))) begin
            st_d      = UNLOCKED;
            win_cnt_d = '0;
            win_err_d = '0;
          end else if (win_cnt_q ==
              WIN_W'(P_WIN - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            win_err_d = win_err_q + WE_W'(mis);
          end
        end
        default: begin
          st_d = UNLOCKED;
        end
      endcase
    end
  end

  // saturating word and word-error counters, clear wins
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (clear_cnt_i) begin
      word_cnt_d = '0;
      err_cnt_d  = '0;
    end else begin
      if (inc_word && (word_cnt_q != '1)) begin
        word_cnt_d = word_cnt_q + P_CNT_W'(1);
      end
      if (inc_err && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + P_CNT_W'(1);
      end
    end
  end

  // state and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q       <= UNLOCKED;
      seed_q     <= '0;
      lfsr_q     <= '0;
      lock_cnt_q <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      word_err_q <= 1'b0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      st_q       <= st_d;
      seed_q     <= seed_d;
      lfsr_q     <= lfsr_d;
      lock_cnt_q <= lock_cnt_d;
      win_cnt_q  <= win_cnt_d;
      win_err_q  <= win_err_d;
      word_err_q <= word_err_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign locked_o   = st_q == LOCKED;
  assign word_err_o = word_err_q;
  assign word_cnt_o = word_cnt_q;
  assign err_cnt_o  = err_cnt_q;

`ifdef PRBS_BIT_ERR_CNT_EN
  logic [P_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [6:0]         pop_w;
  logic [P_CNT_W:0]   bsum_w;

  assign pop_w  = 7'($countones(data_w ^ exp_w));
  assign bsum_w = {1'b0, bit_cnt_q}
                + (P_CNT_W + 1)'(pop_w);

  // saturating bit error accumulation, clear wins
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (clear_cnt_i) begin
      bit_cnt_d = '0;
    end else if (inc_word) begin
      bit_cnt_d = bsum_w[P_CNT_W] ? '1
                : bsum_w[P_CNT_W-1:0];
    end
  end

  // bit error counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bit_err_cnt_o = bit_cnt_q;
`else
  assign bit_err_cnt_o = '0;
`endif

endmodule
